hidden_forward: RTL

//  Forward-pass engine for a single hidden neuron feeding a single output neuron.
//  - Serially accumulates bias + sum(x_k ? w_k : 0) over the 4 binary inputs.
//  - Applies ReLU, then multiplies by the output weight.
//  - Produces hidden_val_o and final_o, which hidden_backprop consumes as

---
 rtl/nn_pkg.sv | 19 +
 rtl/hidden_forward_if.sv | 36 +++
 rtl/relu_sat.sv | 35 +++
 rtl/hidden_forward.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the small neural-network datapath.
// Purpose : width constants and the forward-pass state encoding, shared by
//           hidden_forward and the backprop sequencer.
// Ports   : none (package).
package nn_pkg;

    localparam int W_WIDTH   = 8;   // signed weight / bias width
    localparam int HID_WIDTH = 10;  // unsigned hidden activation width
    localparam int FIN_WIDTH = 19;  // signed final output width
    localparam int NUM_IN    = 4;   // binary inputs per hidden neuron

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ACT,
        MUL
    } fwd_state_t;

endpackage

// File: rtl/hidden_forward_if.sv
// Handshake and operand bus for hidden_forward.
// Purpose : groups start/flush/operands (driven by the master) and the
//           result/status signals (driven by the slave engine).
// Signals : start_i, flush_i, x_i[NUM_IN], w0_i..w3_i, bias_i, wout_i  (master -> slave)
//           hidden_val_o[HID_WIDTH], final_o[FIN_WIDTH], busy_o, done_o (slave -> master)
interface hidden_forward_if #(
    parameter int W_WIDTH   = nn_pkg::W_WIDTH,
    parameter int HID_WIDTH = nn_pkg::HID_WIDTH,
    parameter int FIN_WIDTH = nn_pkg::FIN_WIDTH
);

    logic                      start_i;
    logic                      flush_i;
    logic [nn_pkg::NUM_IN-1:0] x_i;
    logic [W_WIDTH-1:0]        w0_i;
    logic [W_WIDTH-1:0]        w1_i;
    logic [W_WIDTH-1:0]        w2_i;
    logic [W_WIDTH-1:0]        w3_i;
    logic [W_WIDTH-1:0]        bias_i;
    logic [W_WIDTH-1:0]        wout_i;
    logic [HID_WIDTH-1:0]      hidden_val_o;
    logic [FIN_WIDTH-1:0]      final_o;
    logic                      busy_o;
    logic                      done_o;

    modport master (
        output start_i, flush_i, x_i, w0_i, w1_i, w2_i, w3_i, bias_i, wout_i,
        input  hidden_val_o, final_o, busy_o, done_o
    );

    modport slave (
        input  start_i, flush_i, x_i, w0_i, w1_i, w2_i, w3_i, bias_i, wout_i,
        output hidden_val_o, final_o, busy_o, done_o
    );

endinterface

// File: rtl/relu_sat.sv
// ReLU with width reduction for the hidden activation.
// Purpose : converts the signed accumulator to an unsigned HID_WIDTH value;
//           negative inputs give 0.
// Macro   : HIDDEN_FWD_SATURATE_EN - when defined, positive values above
//           2^HID_WIDTH-1 clamp to 2^HID_WIDTH-1; otherwise they wrap
//           (low HID_WIDTH bits kept).
// Ports   : acc_i  [ACC_W]     signed accumulator
//           relu_o [HID_WIDTH] unsigned activation
module relu_sat #(
    parameter int ACC_W     = nn_pkg::W_WIDTH + 3,
    parameter int HID_WIDTH = nn_pkg::HID_WIDTH
) (
    input  logic signed [ACC_W-1:0]     acc_i,
    output logic        [HID_WIDTH-1:0] relu_o
);

`ifdef HIDDEN_FWD_SATURATE_EN
    // One guard bit over the wider of the two widths keeps the compare valid
    // whether HID_WIDTH is narrower or wider than the accumulator.
    localparam int EXT_W = ((ACC_W > HID_WIDTH) ? ACC_W : HID_WIDTH) + 1;
    localparam logic [EXT_W-1:0] HID_MAX = EXT_W'((64'd1 << HID_WIDTH) - 64'd1);

    logic [EXT_W-1:0] mag;

    always_comb begin
        mag    = acc_i[ACC_W-1] ? '0 : EXT_W'($unsigned(acc_i));
        relu_o = (mag > HID_MAX) ? '1 : HID_WIDTH'(mag);
    end
`else
    always_comb begin
        relu_o = acc_i[ACC_W-1] ? '0 : HID_WIDTH'($unsigned(acc_i));
    end
`endif

endmodule

// File: rtl/hidden_forward.sv
// Forward pass for one hidden neuron feeding one output neuron.
// Purpose : acc = bias + sum(x_k ? w_k : 0) accumulated serially, then
//           hidden = ReLU(acc), final = hidden * wout. Start/busy/done handshake.
// Macro   : HIDDEN_FWD_SATURATE_EN (clamp vs wrap of the ReLU result, see relu_sat).
// Ports   : clk_i  rising-edge clock
//           rst_i  synchronous active-high reset
//           bus    hidden_forward_if.slave (start/flush/operands in, results out)
// Timing  : start accepted at T0, hidden_val_o at T5, final_o/done_o at T6,
//           next start accepted at T7 at the earliest.
module hidden_forward #(
    parameter int W_WIDTH   = nn_pkg::W_WIDTH,
    parameter int HID_WIDTH = nn_pkg::HID_WIDTH,
    parameter int FIN_WIDTH = nn_pkg::FIN_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    hidden_forward_if.slave bus
);
    import nn_pkg::*;

    localparam int ACC_W  = W_WIDTH + 3;
    localparam int PROD_W = HID_WIDTH + W_WIDTH + 1;
    localparam int IDX_W  = $clog2(NUM_IN);

    fwd_state_t                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [NUM_IN-1:0]         x_q, x_d;
    logic signed [W_WIDTH-1:0] w_q [NUM_IN];
    logic signed [W_WIDTH-1:0] w_d [NUM_IN];
    logic signed [W_WIDTH-1:0] wout_q, wout_d;
    logic [HID_WIDTH-1:0]      hidden_q, hidden_d;
    logic [FIN_WIDTH-1:0]      final_q, final_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [HID_WIDTH-1:0]      relu_val;
    logic signed [PROD_W-1:0]  prod;

    relu_sat #(
        .ACC_W    (ACC_W),
        .HID_WIDTH(HID_WIDTH)
    ) u_relu (
        .acc_i (acc_q),
        .relu_o(relu_val)
    );

    // Hidden value is zero-extended so it is never read as negative.
    always_comb begin
        prod = PROD_W'($signed({1'b0, hidden_q})) * PROD_W'(wout_q);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        x_d      = x_q;
        w_d      = w_q;
        wout_d   = wout_q;
        hidden_d = hidden_q;
        final_d  = final_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // flush in IDLE suppresses a simultaneous start
                if (bus.start_i && !bus.flush_i) begin
                    x_d     = bus.x_i;
                    w_d[0]  = $signed(bus.w0_i);
                    w_d[1]  = $signed(bus.w1_i);
                    w_d[2]  = $signed(bus.w2_i);
                    w_d[3]  = $signed(bus.w3_i);
                    wout_d  = $signed(bus.wout_i);
                    acc_d   = ACC_W'($signed(bus.bias_i));
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (x_q[idx_q]) begin
                    acc_d = acc_q + ACC_W'(w_q[idx_q]);
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_IN - 1)) begin
                    state_d = ACT;
                end
            end
            ACT: begin
                hidden_d = relu_val;
                state_d  = MUL;
            end
            MUL: begin
                final_d = FIN_WIDTH'(prod);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort: results keep whatever ACT/MUL already committed.
        if (bus.flush_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            hidden_d = hidden_q;
            final_d  = final_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                w_q[i] <= '0;
            end
            wout_q   <= '0;
            hidden_q <= '0;
            final_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            w_q      <= w_d;
            wout_q   <= wout_d;
            hidden_q <= hidden_d;
            final_q  <= final_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.hidden_val_o = hidden_q;
    assign bus.final_o      = final_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;

endmodule
